bcd_gray_pipe: RTL and testbench
================================

BCD_GRAY_PIPE -- requirements
Module: bcd_gray_pipe

Interface
REQ-001 SHALL have parameter DIGITS, default 4, the number of BCD digits per word (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, the error-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input word is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a word.
REQ-007 SHALL have port in_bcd, input, 4*DIGITS, packed BCD with digit 0 in bits [3:0].
REQ-008 SHALL have port in_mode, input, 1: 0 = per-digit Gray, 1 = whole-number Gray.
REQ-009 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept.
REQ-011 SHALL have port out_gray, output, 4*DIGITS, the result.
REQ-012 SHALL have port out_err, output, 1, meaning the accepted word held a digit >9.
REQ-013 SHALL have port err_cnt, output, CNT_W, the saturating count of erroneous transactions.

Function
REQ-014 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE.
REQ-015 SHALL assert in_ready only in IDLE; acceptance is in_valid & in_ready at a clock edge.
REQ-016 SHALL capture in_bcd and in_mode at acceptance; later input changes are ignored until the next acceptance.
REQ-017 SHALL hold CONV for 1 cycle in mode 0 and for DIGITS cycles in mode 1, using a digit counter.
REQ-018 Mode 0 SHALL compute each 4-bit output digit as g = d ^ (d >> 1), applied per digit independently.
REQ-019 Mode 1 SHALL accumulate bin = bin*10 + digit, most significant digit first, one digit per CONV cycle.
REQ-020 Mode 1 SHALL then output gray = bin ^ (bin >> 1), zero-extended to 4*DIGITS bits; no overflow is possible because 10^DIGITS < 16^DIGITS.
REQ-021 SHALL produce out_valid in cycle k+1+N, where k is the acceptance cycle and N is the CONV length (mode 0: k+2; mode 1, DIGITS=4: k+5).
REQ-022 SHALL hold out_valid, out_gray and out_err stable in DONE until out_ready=1, then return to IDLE at the next edge.
REQ-023 SHALL provide no bypass path: in_ready is 0 in the DONE cycle even when out_ready=1, giving one transaction per N+2 cycles at most.
REQ-024 SHALL set out_err=1 and force out_gray to 0 if any captured digit exceeds 9, in either mode, with the same latency.
REQ-025 SHALL increment err_cnt by 1 at the output handshake of each erroneous transaction, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL drive out_gray and out_err to 0 whenever out_valid=0.

Reset
REQ-027 On reset=1 at an edge, SHALL go to IDLE, discard any in-flight word, and clear err_cnt, the digit counter and the accumulator.
REQ-028 SHALL hold out_valid=0, out_gray=0, out_err=0 and in_ready=0 while reset is high, and set in_ready=1 in the first cycle after reset deasserts.
REQ-029 Reset SHALL take priority over every handshake that occurs in the same cycle.

Structure
REQ-030 Package bcd_gray_pkg SHALL hold the state enum (IDLE, CONV, DONE), the mode constants MODE_DIGIT=0 and MODE_WORD=1, and a digit-to-Gray function.
REQ-031 SHALL instantiate sub-module bcd_digit_gray (4-bit combinational digit-to-Gray converter plus >9 flag) once per digit in a generate loop.
REQ-032 Implementation size SHALL be 120-400 RTL lines.

Verification (DIGITS=4, CNT_W=8)
REQ-033 Mode 0, in_bcd=0x1234 -> out_gray=0x1326, out_err=0, out_valid in cycle k+2.
REQ-034 Mode 1, in_bcd=0x9999 -> out_gray=0x3488, out_valid in cycle k+5; in_bcd=0x0010 -> out_gray=0x000F.
REQ-035 in_bcd=0x12A4 in either mode -> out_err=1, out_gray=0, err_cnt 0->1 at the output handshake; 256 such words -> err_cnt holds 255.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_gray stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 in the next cycle.
REQ-037 reset=1 in the second CONV cycle of mode 1 -> next cycle IDLE with out_valid=0, err_cnt=0 and no output handshake for the aborted word.
REQ-038 in_mode toggled during CONV -> the result matches the mode captured at acceptance.

Source files
------------

// File: rtl/bcd_gray_pkg.sv
// Shared types and helpers for the BCD-to-Gray pipeline.
package bcd_gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_DIGIT = 1'b0;
    localparam logic MODE_WORD  = 1'b1;

    function automatic logic [3:0] digit_to_gray(input logic [3:0] d);
        return d ^ {1'b0, d[3:1]};
    endfunction

endpackage

// File: rtl/bcd_gray_pipe_digit.sv
// Single BCD digit to 4-bit Gray code, with a flag for non-decimal codes.
module bcd_digit_gray
    import bcd_gray_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] gray_o,
    output logic       err_o
);

    assign gray_o = digit_to_gray(digit_i);
    assign err_o  = (digit_i > 4'd9);

endmodule

// File: rtl/bcd_gray_pipe.sv
// BCD word to Gray code converter: per-digit Gray or Gray of the whole
// decimal value, with a valid/ready handshake and a saturating error count.
//
// state | meaning
// IDLE  | in_ready high, waiting for a word
// CONV  | converting; 1 cycle per-digit mode, DIGITS cycles whole-word mode
// DONE  | result held on out_* until out_ready
module bcd_gray_pipe
    import bcd_gray_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_gray,
    output logic                  out_err,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e           state_q;
    logic [W-1:0]     bcd_q;
    logic             mode_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     gray_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [W-1:0]      digit_gray;
    logic [DIGITS-1:0] digit_err;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_gray u_digit (
            .digit_i (bcd_q[4*i +: 4]),
            .gray_o  (digit_gray[4*i +: 4]),
            .err_o   (digit_err[i])
        );
    end

    logic         any_err;
    logic         last_conv;
    logic [3:0]   cur_digit;
    logic [W-1:0] acc_d;
    logic [W-1:0] word_gray;
    logic [W-1:0] result_d;

    // Whole-word mode walks the digits MSD first; the down-counter is the digit index.
    always_comb begin
        any_err   = |digit_err;
        last_conv = (idx_q == '0);
        cur_digit = 4'(bcd_q >> {idx_q, 2'b00});
        acc_d     = acc_q * W'(10) + W'(cur_digit);
        word_gray = acc_d ^ (acc_d >> 1);
        result_d  = '0;
        if (!any_err) begin
            result_d = (mode_q == MODE_WORD) ? word_gray : digit_gray;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            mode_q    <= MODE_DIGIT;
            idx_q     <= '0;
            acc_q     <= '0;
            gray_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q   <= in_bcd;
                        mode_q  <= in_mode;
                        idx_q   <= (in_mode == MODE_WORD) ? LAST_IDX : '0;
                        acc_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q <= acc_d;
                    if (last_conv) begin
                        gray_q  <= result_d;
                        err_q   <= any_err;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        gray_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                        if (err_q && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE) && !reset;
    assign out_gray  = out_valid ? gray_q : '0;
    assign out_err   = out_valid && err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bcd_gray_pipe.sv
// Directed scoreboard bench for bcd_gray_pipe with DIGITS=4, CNT_W=8.
module tb_bcd_gray_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_gray;
    logic        out_err;
    logic [7:0]  err_cnt;

    bcd_gray_pipe #(.DIGITS(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;
    int exp_err_cnt = 0;

    typedef struct {
        logic [15:0] gray;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] b, input logic m,
                                  output logic [15:0] g, output logic e);
        int bin;
        logic [3:0] d;
        bin = 0;
        e   = 1'b0;
        g   = '0;
        for (int i = 3; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            bin = bin * 10 + int'(d);
            g[4*i +: 4] = d ^ (d >> 1);
        end
        if (m) g = 16'(bin ^ (bin >> 1));
        if (e) g = '0;
    endfunction

    // Drives one word; after acceptance the inputs are scrambled and the mode flipped.
    task automatic send(input logic [15:0] b, input logic m, input logic [15:0] g,
                        input logic e, input bit track);
        bit got;
        got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = b;
        in_mode  = m;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(got), 32'd1);
        if (track) sb.push_back('{g, e, cyc + 1 + (m ? 4 : 1)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        in_mode  = ~m;
    endtask

    task automatic model_send(input logic [15:0] b, input logic m);
        logic [15:0] g;
        logic        e;
        model(b, m, g, e);
        send(b, m, g, e, 1'b1);
    endtask

    task automatic receive(input int hold);
        exp_t ex;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("out_valid_timeout", 32'(got), 32'd1);
        if (!got || sb.size() == 0) return;
        ex = sb.pop_front();
        check("latency", 32'(cyc), 32'(ex.cyc));
        check("out_gray", 32'(out_gray), 32'(ex.gray));
        check("out_err", 32'(out_err), 32'(ex.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_gray", 32'(out_gray), 32'(ex.gray));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        check("in_ready_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        if (ex.err && exp_err_cnt < 255) exp_err_cnt++;
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("valid_after", 32'(out_valid), 32'd0);
        check("gray_idle", 32'(out_gray), 32'd0);
        check("err_idle", 32'(out_err), 32'd0);
    endtask

    initial begin
        logic [15:0] b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bcd    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_gray", 32'(out_gray), 32'd0);
            check("rst_out_err", 32'(out_err), 32'd0);
            check("rst_err_cnt", 32'(err_cnt), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("in_ready_post_rst", 32'(in_ready), 32'd1);

        send(16'h1234, 1'b0, 16'h1326, 1'b0, 1'b1);
        receive(0);
        send(16'h9999, 1'b1, 16'h3488, 1'b0, 1'b1);
        receive(0);
        send(16'h0010, 1'b1, 16'h000F, 1'b0, 1'b1);
        receive(0);
        send(16'h12A4, 1'b0, 16'h0000, 1'b1, 1'b1);
        receive(0);
        send(16'h12A4, 1'b1, 16'h0000, 1'b1, 1'b1);
        receive(0);

        model_send(16'h1234, 1'b1);
        receive(5);
        model_send(16'h0000, 1'b0);
        receive(1);
        model_send(16'h9999, 1'b0);
        receive(0);

        for (int i = 0; i < 8; i++) begin
            b = '0;
            for (int j = 0; j < 4; j++) b[4*j +: 4] = 4'($urandom_range(0, 9));
            model_send(b, 1'($urandom_range(0, 1)));
            receive(int'($urandom_range(0, 2)));
        end

        // Abort a whole-word conversion in its second CONV cycle.
        send(16'h9999, 1'b1, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_valid_in_rst", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_err_cnt = 0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_output", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 256; i++) begin
            send(16'h12A4, 1'(i % 2), 16'h0000, 1'b1, 1'b1);
            receive(0);
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        send(16'h12A4, 1'b0, 16'h0000, 1'b1, 1'b1);
        receive(0);
        check("err_cnt_no_wrap", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
